// File: rtl/ysyx_22040237_mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter.
package ysyx_22040237_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_t;

  localparam int ARB_STREAK_MAX_DEF = 4;

endpackage

// File: rtl/ysyx_22040237_arb_pick.sv
// Priority selection between IFU and LSU with an LSU-streak starvation guard.
module ysyx_22040237_arb_pick #(
  parameter int STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] CAP = SW'(STREAK_MAX);

  logic [SW-1:0] streak;
  logic          ifu_turn;

  // IFU only wins a contested grant once LSU has used up its streak.
  assign ifu_turn  = ifu_valid && (streak == CAP);
  assign grant_lsu = en && lsu_valid && !ifu_turn;
  assign grant_ifu = en && ifu_valid && !grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_ifu) begin
      streak <= '0;
    end else if (grant_lsu) begin
      if (!ifu_valid) begin
        streak <= '0;
      end else if (streak != CAP) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_22040237_mem_arb.sv
// Single-outstanding memory port sequencer shared by IFU and LSU.
module ysyx_22040237_mem_arb
  import ysyx_22040237_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STREAK_MAX = ARB_STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_rsp_valid_o,
  output logic [DATA_W-1:0]   ifu_rsp_data_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_rsp_valid_o,
  output logic [DATA_W-1:0]   lsu_rsp_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_W-1:0]   mem_rsp_data_i
);

  arb_state_t          state, state_nxt;
  arb_owner_t          owner;
  logic [ADDR_W-1:0]   addr;
  logic                wen;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                arb_en;
  logic                grant_ifu, grant_lsu;
  logic                rsp_hit;

  // Gating with rst_n keeps both readies low for the whole reset pulse.
  assign arb_en = rst_n && (state == ARB_IDLE);

  ysyx_22040237_arb_pick #(
    .STREAK_MAX(STREAK_MAX)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .ifu_valid(ifu_req_valid_i),
    .lsu_valid(lsu_req_valid_i),
    .grant_ifu(grant_ifu),
    .grant_lsu(grant_lsu)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (grant_ifu || grant_lsu) state_nxt = ARB_REQ;
      ARB_REQ:  if (mem_req_ready_i)        state_nxt = ARB_WAIT;
      ARB_WAIT: if (mem_rsp_valid_i)        state_nxt = ARB_IDLE;
      default:                              state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= ARB_OWN_IFU;
      addr  <= '0;
      wen   <= 1'b0;
      wdata <= '0;
      wmask <= '0;
    end else if (grant_lsu) begin
      owner <= ARB_OWN_LSU;
      addr  <= lsu_addr_i;
      wen   <= lsu_wen_i;
      wdata <= lsu_wdata_i;
      wmask <= lsu_wmask_i;
    end else if (grant_ifu) begin
      owner <= ARB_OWN_IFU;
      addr  <= ifu_addr_i;
      wen   <= 1'b0;
      wdata <= '0;
      wmask <= '0;
    end
  end

  assign ifu_req_ready_o = grant_ifu;
  assign lsu_req_ready_o = grant_lsu;

  assign mem_req_valid_o = (state == ARB_REQ);
  assign mem_addr_o      = addr;
  assign mem_wen_o       = wen;
  assign mem_wdata_o     = wdata;
  assign mem_wmask_o     = wmask;

  assign rsp_hit         = (state == ARB_WAIT) && mem_rsp_valid_i;
  assign ifu_rsp_valid_o = rsp_hit && (owner == ARB_OWN_IFU);
  assign lsu_rsp_valid_o = rsp_hit && (owner == ARB_OWN_LSU);
  assign ifu_rsp_data_o  = mem_rsp_data_i;
  assign lsu_rsp_data_o  = mem_rsp_data_i;

endmodule
